// File: rtl/led_seq_pkg.sv
// Shared encodings for the LED sequencer: pattern modes, controller states
// and the reset seed pattern.
package led_seq_pkg;

  localparam int unsigned MODE_W = 3;

  // Pattern modes; 5..7 are undefined and behave as HOLD
  localparam logic [MODE_W-1:0] MODE_HOLD   = 3'd0;
  localparam logic [MODE_W-1:0] MODE_BOUNCE = 3'd1;
  localparam logic [MODE_W-1:0] MODE_ROT_L  = 3'd2;
  localparam logic [MODE_W-1:0] MODE_ROT_R  = 3'd3;
  localparam logic [MODE_W-1:0] MODE_BLINK  = 3'd4;

  // Controller states
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Seed is MSB-only; instances take the top WIDTH bits (WIDTH <= 64)
  localparam int unsigned SEED_MAX_W       = 64;
  localparam logic [SEED_MAX_W-1:0] DEFAULT_SEED_MAX = {1'b1, {(SEED_MAX_W-1){1'b0}}};

  // Reset duty for the optional PWM dimmer
  localparam int unsigned DUTY_W       = 4;
  localparam logic [DUTY_W-1:0] DUTY_RESET = 4'hF;

endpackage : led_seq_pkg

// File: rtl/led_seq_tick.sv
// Step-period counter: emits a single-cycle tick every i_period clocks
// while enabled; a period of 0 is treated as 1. i_clr holds it at zero.
module led_seq_tick #(
  parameter int unsigned PERIOD_W = 22
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_clr,
  input  logic                i_en,
  input  logic [PERIOD_W-1:0] i_period,
  output logic                o_tick_c
);

  logic [PERIOD_W-1:0] r_cnt;
  logic [PERIOD_W-1:0] w_last;

  // Terminal count; period 0 collapses onto period 1
  always_comb begin
    w_last = '0;
    if (i_period != '0) begin
      w_last = i_period - PERIOD_W'(1);
    end
  end

  assign o_tick_c = i_en && !i_clr && (r_cnt == w_last);

  // Counter wraps on tick; >= keeps it bounded should the period shrink
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (r_cnt >= w_last) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + PERIOD_W'(1);
      end
    end
  end

endmodule : led_seq_tick

// File: rtl/led_seq_ctrl.sv
// LED sequencer controller: holds a host-loaded configuration and steps the
// LED register through hold/bounce/rotate/blink patterns on a programmable
// tick, counting passes and reporting busy/done.
// Optional build macro: LED_SEQ_PWM_EN adds a cfg_duty input and a 4-bit
// PWM dimmer on the LED outputs.
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PERIOD_W = 22,
  parameter int unsigned PASS_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [MODE_W-1:0]   cfg_mode,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [WIDTH-1:0]    cfg_pattern,
  input  logic [PASS_W-1:0]   cfg_passes,
`ifdef LED_SEQ_PWM_EN
  input  logic [DUTY_W-1:0]   cfg_duty,
`endif
  input  logic                start,
  input  logic                stop,
  output logic                busy,
  output logic                done,
  output logic [WIDTH-1:0]    led
);

  localparam int unsigned STEP_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] SEED = DEFAULT_SEED_MAX[SEED_MAX_W-1 -: WIDTH];

  // Registered state
  logic [0:0]          r_state;
  logic [MODE_W-1:0]   r_mode;
  logic [PERIOD_W-1:0] r_period;
  logic [WIDTH-1:0]    r_pattern;
  logic [PASS_W-1:0]   r_passes;
  logic [WIDTH-1:0]    r_led;
  logic                r_dir;
  logic [STEP_W-1:0]   r_step;
  logic [PASS_W-1:0]   r_pass_cnt;
  logic                r_done;
  logic                r_busy;
  logic                r_cfg_ready;

  // Next-state values
  logic [0:0]          w_state_nxt;
  logic [MODE_W-1:0]   w_mode_nxt;
  logic [PERIOD_W-1:0] w_period_nxt;
  logic [WIDTH-1:0]    w_pattern_nxt;
  logic [PASS_W-1:0]   w_passes_nxt;
  logic [WIDTH-1:0]    w_led_nxt;
  logic                w_dir_nxt;
  logic [STEP_W-1:0]   w_step_nxt;
  logic [PASS_W-1:0]   w_pass_nxt;
  logic                w_done_nxt;
  logic                w_busy_nxt;
  logic                w_cfg_ready_nxt;

  logic                w_cfg_cap;
  logic                w_tick;
  logic                w_pass_evt;
  logic [WIDTH-1:0]    w_rot_l;
  logic [WIDTH-1:0]    w_rot_r;

`ifdef LED_SEQ_PWM_EN
  logic [DUTY_W-1:0]   r_duty;
  logic [DUTY_W-1:0]   w_duty_nxt;
  logic [DUTY_W-1:0]   r_pwm_cnt;
`endif

  // Rotations of the current LED register
  assign w_rot_l = {r_led[WIDTH-2:0], r_led[WIDTH-1]};
  assign w_rot_r = {r_led[0], r_led[WIDTH-1:1]};

  // Config is only accepted while idle; writes during a run are dropped
  assign w_cfg_cap = cfg_valid && (r_state == ST_IDLE);

  // Step tick generator, held cleared while idle so a run starts from zero
  led_seq_tick #(
    .PERIOD_W (PERIOD_W)
  ) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (r_state == ST_IDLE),
    .i_en     (r_state == ST_RUN),
    .i_period (r_period),
    .o_tick_c (w_tick)
  );

  // Next-state, pattern datapath and pass counting
  always_comb begin
    w_state_nxt   = r_state;
    w_mode_nxt    = r_mode;
    w_period_nxt  = r_period;
    w_pattern_nxt = r_pattern;
    w_passes_nxt  = r_passes;
    w_led_nxt     = r_led;
    w_dir_nxt     = r_dir;
    w_step_nxt    = r_step;
    w_pass_nxt    = r_pass_cnt;
    w_done_nxt    = 1'b0;
    w_pass_evt    = 1'b0;
`ifdef LED_SEQ_PWM_EN
    w_duty_nxt    = r_duty;
`endif

    if (w_cfg_cap) begin
      w_mode_nxt    = cfg_mode;
      w_period_nxt  = cfg_period;
      w_pattern_nxt = cfg_pattern;
      w_passes_nxt  = cfg_passes;
`ifdef LED_SEQ_PWM_EN
      w_duty_nxt    = cfg_duty;
`endif
    end

    case (r_state)
      ST_IDLE: begin
        // A config written in the same cycle as start is the one used
        if (start && !stop) begin
          w_state_nxt = ST_RUN;
          w_led_nxt   = w_cfg_cap ? cfg_pattern : r_pattern;
          w_dir_nxt   = 1'b0;
          w_step_nxt  = '0;
          w_pass_nxt  = '0;
        end
      end

      ST_RUN: begin
        if (stop) begin
          // Abort wins over any step or completion this cycle
          w_state_nxt = ST_IDLE;
          w_led_nxt   = '0;
        end else if (w_tick) begin
          case (r_mode)
            MODE_BOUNCE: begin
              if (!r_dir) begin
                w_led_nxt = w_rot_r;
                if (w_rot_r[0]) begin
                  w_dir_nxt = 1'b1;
                end
              end else begin
                w_led_nxt = w_rot_l;
                if (w_rot_l[WIDTH-1]) begin
                  w_dir_nxt  = 1'b0;
                  w_pass_evt = 1'b1;
                end
              end
            end

            MODE_ROT_L, MODE_ROT_R: begin
              w_led_nxt = (r_mode == MODE_ROT_L) ? w_rot_l : w_rot_r;
              if (r_step == STEP_W'(WIDTH - 1)) begin
                w_step_nxt = '0;
                w_pass_evt = 1'b1;
              end else begin
                w_step_nxt = r_step + STEP_W'(1);
              end
            end

            MODE_BLINK: begin
              w_led_nxt = r_led ^ r_pattern;
              if (r_step == STEP_W'(1)) begin
                w_step_nxt = '0;
                w_pass_evt = 1'b1;
              end else begin
                w_step_nxt = r_step + STEP_W'(1);
              end
            end

            default: begin
              // HOLD and unused encodings: LEDs frozen, every tick is a pass
              w_pass_evt = 1'b1;
            end
          endcase

          if (w_pass_evt) begin
            w_pass_nxt = (&r_pass_cnt) ? r_pass_cnt : r_pass_cnt + PASS_W'(1);
            if ((r_passes != '0) && (w_pass_nxt == r_passes)) begin
              w_state_nxt = ST_IDLE;
              w_done_nxt  = 1'b1;
            end
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_busy_nxt      = (w_state_nxt == ST_RUN);
    w_cfg_ready_nxt = (w_state_nxt == ST_IDLE);
  end

  // State and configuration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_mode      <= MODE_HOLD;
      r_period    <= PERIOD_W'(1);
      r_pattern   <= SEED;
      r_passes    <= '0;
      r_led       <= '0;
      r_dir       <= 1'b0;
      r_step      <= '0;
      r_pass_cnt  <= '0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_cfg_ready <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_mode      <= w_mode_nxt;
      r_period    <= w_period_nxt;
      r_pattern   <= w_pattern_nxt;
      r_passes    <= w_passes_nxt;
      r_led       <= w_led_nxt;
      r_dir       <= w_dir_nxt;
      r_step      <= w_step_nxt;
      r_pass_cnt  <= w_pass_nxt;
      r_done      <= w_done_nxt;
      r_busy      <= w_busy_nxt;
      r_cfg_ready <= w_cfg_ready_nxt;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign cfg_ready = r_cfg_ready;

`ifdef LED_SEQ_PWM_EN
  // Duty register and free-running PWM phase counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty    <= DUTY_RESET;
      r_pwm_cnt <= '0;
    end else begin
      r_duty    <= w_duty_nxt;
      r_pwm_cnt <= r_pwm_cnt + DUTY_W'(1);
    end
  end

  assign led = r_led & {WIDTH{r_pwm_cnt < r_duty}};
`else
  assign led = r_led;
`endif

endmodule : led_seq_ctrl

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl: expected {led,busy,done,cfg_ready}
// values are queued as stimulus is applied and checked at falling edges.
module tb_led_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [2:0]  cfg_mode;
  logic [21:0] cfg_period;
  logic [7:0]  cfg_pattern;
  logic [7:0]  cfg_passes;
  logic        start;
  logic        stop;
  logic        busy;
  logic        done;
  logic [7:0]  led;
`ifdef LED_SEQ_PWM_EN
  logic [3:0]  cfg_duty;
`endif

  led_seq_ctrl #(
    .WIDTH    (8),
    .PERIOD_W (22),
    .PASS_W   (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_mode    (cfg_mode),
    .cfg_period  (cfg_period),
    .cfg_pattern (cfg_pattern),
    .cfg_passes  (cfg_passes),
`ifdef LED_SEQ_PWM_EN
    .cfg_duty    (cfg_duty),
`endif
    .start       (start),
    .stop        (stop),
    .busy        (busy),
    .done        (done),
    .led         (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] v;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic push(input logic [7:0] l, input logic b, input logic d,
                      input logic r, input string t);
    exp_t e;
    e.v   = {l, b, d, r};
    e.tag = t;
    sb.push_back(e);
  endtask

  task automatic push_run(input logic [7:0] l, input string t);
    push(l, 1'b1, 1'b0, 1'b0, t);
  endtask

  task automatic push_idle(input logic [7:0] l, input string t);
    push(l, 1'b0, 1'b0, 1'b1, t);
  endtask

  task automatic pop_check();
    exp_t        e;
    logic [10:0] obs;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty: got no expectation, required one queued");
    end else begin
      e   = sb.pop_front();
      obs = {led, busy, done, cfg_ready};
      assert (obs === e.v) else begin
        n_fail++;
        $error("FAIL %s: got led=%h busy=%b done=%b rdy=%b, required led=%h busy=%b done=%b rdy=%b",
               e.tag, obs[10:3], obs[2], obs[1], obs[0], e.v[10:3], e.v[2], e.v[1], e.v[0]);
      end
    end
  endtask

  task automatic step_check();
    @(negedge clk);
    pop_check();
  endtask

  task automatic drain();
    while (sb.size() != 0) step_check();
  endtask

  // Drive a start (optionally with config) for exactly one rising edge
  task automatic launch(input logic [2:0] m, input logic [21:0] p, input logic [7:0] pat,
                        input logic [7:0] n, input logic use_cfg);
    cfg_mode    = m;
    cfg_period  = p;
    cfg_pattern = pat;
    cfg_passes  = n;
    cfg_valid   = use_cfg;
    start       = 1'b1;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    start     = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  logic [7:0] bounce_tbl [15];

  initial begin
    bounce_tbl = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
                   8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_mode = '0; cfg_period = '0;
    cfg_pattern = '0; cfg_passes = '0; start = 1'b0; stop = 1'b0;
`ifdef LED_SEQ_PWM_EN
    cfg_duty = 4'hF;
`endif

    // Reset values
    push_idle(8'h00, "reset");
    step_check();
    @(negedge clk);
    rst_n = 1'b1;

    // stop in IDLE blocks start
    start = 1'b1; stop = 1'b1;
    push_idle(8'h00, "stop_blocks_start");
    push_idle(8'h00, "stop_blocks_start");
    drain();
    start = 1'b0; stop = 1'b0;

    // BOUNCE 0x80, period 1, one pass
    launch(3'd1, 22'd1, 8'h80, 8'd1, 1'b1);
    for (int k = 0; k < 14; k++) push_run(bounce_tbl[k], "bounce_step");
    push(8'h80, 1'b0, 1'b1, 1'b1, "bounce_done");
    push_idle(8'h80, "bounce_after");
    drain();

    // ROT_L 0x81, period 3, two passes
    launch(3'd2, 22'd3, 8'h81, 8'd2, 1'b1);
    for (int k = 0; k < 48; k++) push_run(rotl8(8'h81, k / 3), "rotl_step");
    push(8'h81, 1'b0, 1'b1, 1'b1, "rotl_done");
    push_idle(8'h81, "rotl_after");
    drain();

    // BLINK 0x0F, period 2, run forever, then stop
    launch(3'd4, 22'd2, 8'h0F, 8'd0, 1'b1);
    for (int k = 0; k < 12; k++) push_run(((k / 2) % 2) ? 8'h00 : 8'h0F, "blink_step");
    drain();
    stop = 1'b1;
    push_idle(8'h00, "blink_stop");
    step_check();
    stop = 1'b0;
    push_idle(8'h00, "blink_stop_idle");
    push_idle(8'h00, "blink_stop_idle");
    drain();

    // Config writes during RUN are ignored
    launch(3'd0, 22'd5, 8'h3C, 8'd0, 1'b1);
    for (int k = 0; k < 3; k++) push_run(8'h3C, "hs_run");
    drain();
    cfg_valid = 1'b1; cfg_mode = 3'd3; cfg_period = 22'd1;
    cfg_pattern = 8'h55; cfg_passes = 8'd1;
    for (int k = 0; k < 3; k++) push_run(8'h3C, "hs_ready_low");
    drain();
    cfg_valid = 1'b0;
    stop = 1'b1;
    push_idle(8'h00, "hs_stop");
    step_check();
    stop = 1'b0;
    launch(3'd3, 22'd1, 8'h55, 8'd1, 1'b0);
    for (int k = 0; k < 7; k++) push_run(8'h3C, "hs_cfg_kept");
    drain();
    stop = 1'b1;
    push_idle(8'h00, "hs_stop2");
    step_check();
    stop = 1'b0;

    // Mode 6 holds, period 0 acts as 1, pattern 0xAA loaded with start
    launch(3'd6, 22'd0, 8'hAA, 8'd3, 1'b1);
    for (int k = 0; k < 3; k++) push_run(8'hAA, "m6_hold");
    push(8'hAA, 1'b0, 1'b1, 1'b1, "m6_done");
    push_idle(8'hAA, "m6_after");
    drain();

    // stop in the same cycle as completion: no done, led cleared
    launch(3'd6, 22'd4, 8'h5A, 8'd1, 1'b1);
    for (int k = 0; k < 4; k++) push_run(8'h5A, "sc_run");
    drain();
    stop = 1'b1;
    push_idle(8'h00, "sc_stop_wins");
    step_check();
    stop = 1'b0;
    push_idle(8'h00, "sc_after");
    drain();

    // Asynchronous reset mid-run, then reset config in effect
    launch(3'd1, 22'd1000, 8'h81, 8'd1, 1'b1);
    for (int k = 0; k < 3; k++) push_run(8'h81, "rst_pre");
    drain();
    #2;
    rst_n = 1'b0;
    #1;
    push_idle(8'h00, "rst_async");
    pop_check();
    for (int k = 0; k < 3; k++) push_idle(8'h00, "rst_held");
    drain();
    rst_n = 1'b1;
    launch(3'd2, 22'd7, 8'h33, 8'd5, 1'b0);
    for (int k = 0; k < 5; k++) push_run(8'h80, "rst_default_cfg");
    drain();
    stop = 1'b1;
    push_idle(8'h00, "rst_final_stop");
    step_check();
    stop = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_led_seq_ctrl
